// File: rtl/pkt_wr_ctrl.sv
// -----------------------------------------------------------------------------
// pkt_wr_ctrl
//
// Packet write controller sitting in front of a packet fifo. It parses an
// incoming byte stream of the form
//     header (dest[7:6], length L[5:0]) , L payload bytes , CRC byte
// pushes header and payload into the fifo and, once the CRC byte arrives,
// either commits the stored packet (fifo_wr_ptr_upd) or discards it
// (fifo_flush). The CRC is the XOR of the header and all payload bytes.
// A packet is also discarded if any of its stored bytes hit a full fifo.
//
// Ports
//   clk              : clock, all state changes on the rising edge
//   rst_n            : asynchronous active-low reset
//   data_in[7:0]     : incoming packet byte
//   data_valid       : data_in holds a byte (accepted when in_ready is high)
//   in_ready         : controller can take a byte this cycle
//   fifo_data[7:0]   : byte to the fifo (same as data_in)
//   fifo_push        : write fifo_data into the fifo this cycle
//   fifo_full        : fifo full flag
//   fifo_wr_ptr_upd  : one-cycle pulse committing the stored packet
//   fifo_flush       : one-cycle pulse discarding the stored packet
//   pkt_dest[1:0]    : destination of the last resolved packet
//   good_cnt         : saturating count of committed packets
//   bad_cnt          : saturating count of flushed packets
// -----------------------------------------------------------------------------
module pkt_wr_ctrl #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [7:0]           data_in,
  input  logic                 data_valid,
  output logic                 in_ready,
  output logic [7:0]           fifo_data,
  output logic                 fifo_push,
  input  logic                 fifo_full,
  output logic                 fifo_wr_ptr_upd,
  output logic                 fifo_flush,
  output logic [1:0]           pkt_dest,
  output logic [CNT_WIDTH-1:0] good_cnt,
  output logic [CNT_WIDTH-1:0] bad_cnt
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PAYLOAD = 2'd1,
    CHECK   = 2'd2,
    RESOLVE = 2'd3
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  // Running packet checksum: one XOR step per byte.
  function automatic logic [7:0] crc_step(input logic [7:0] crc,
                                          input logic [7:0] byte_in);
    return crc ^ byte_in;
  endfunction

  state_t                 state_r, state_s;
  logic [5:0]             cnt_r, cnt_s;
  logic [7:0]             crc_r, crc_s;
  logic                   ovf_r, ovf_s;
  logic                   good_r, good_s;
  logic [1:0]             dest_r, dest_s;
  logic [1:0]             pkt_dest_r;
  logic [CNT_WIDTH-1:0]   good_cnt_r;
  logic [CNT_WIDTH-1:0]   bad_cnt_r;
  logic                   accept_s;
  logic                   store_state_s;

  // Byte handshake and fifo write decode.
  always_comb begin
    in_ready      = (state_r != RESOLVE);
    accept_s      = data_valid && in_ready;
    store_state_s = (state_r == IDLE) || (state_r == PAYLOAD);
    fifo_data     = data_in;
    // rst_n is included so the fifo never sees a write while reset is held.
    fifo_push     = accept_s && !fifo_full && store_state_s && rst_n;
  end

  // Next-state and datapath decode of the packet parser.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    crc_s   = crc_r;
    ovf_s   = ovf_r;
    good_s  = good_r;
    dest_s  = dest_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          dest_s = data_in[7:6];
          cnt_s  = data_in[5:0];
          crc_s  = data_in;
          // A header that cannot be stored already spoils the packet.
          ovf_s  = fifo_full;
          if (data_in[5:0] != 6'd0) begin
            state_s = PAYLOAD;
          end else begin
            state_s = CHECK;
          end
        end else begin
          state_s = IDLE;
        end
      end
      PAYLOAD: begin
        if (accept_s) begin
          crc_s = crc_step(crc_r, data_in);
          cnt_s = cnt_r - 6'd1;
          ovf_s = ovf_r | fifo_full;
          if (cnt_r == 6'd1) begin
            state_s = CHECK;
          end else begin
            state_s = PAYLOAD;
          end
        end else begin
          state_s = PAYLOAD;
        end
      end
      CHECK: begin
        if (accept_s) begin
          good_s  = (data_in == crc_r) && !ovf_r;
          state_s = RESOLVE;
        end else begin
          state_s = CHECK;
        end
      end
      RESOLVE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Parser state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      cnt_r   <= 6'd0;
      crc_r   <= 8'd0;
      ovf_r   <= 1'b0;
      good_r  <= 1'b0;
      dest_r  <= 2'd0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      crc_r   <= crc_s;
      ovf_r   <= ovf_s;
      good_r  <= good_s;
      dest_r  <= dest_s;
    end
  end

  // Destination of the packet being resolved; captured with the CRC byte so
  // it stays stable through the commit/flush pulse and until the next CRC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_dest_r <= 2'd0;
    end else if ((state_r == CHECK) && accept_s) begin
      pkt_dest_r <= dest_r;
    end else begin
      pkt_dest_r <= pkt_dest_r;
    end
  end

  // Saturating good/bad packet counters, bumped during the resolve cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      good_cnt_r <= {CNT_WIDTH{1'b0}};
      bad_cnt_r  <= {CNT_WIDTH{1'b0}};
    end else if (state_r == RESOLVE) begin
      if (good_r) begin
        if (good_cnt_r != CNT_MAX) begin
          good_cnt_r <= good_cnt_r + CNT_ONE;
        end else begin
          good_cnt_r <= good_cnt_r;
        end
      end else begin
        if (bad_cnt_r != CNT_MAX) begin
          bad_cnt_r <= bad_cnt_r + CNT_ONE;
        end else begin
          bad_cnt_r <= bad_cnt_r;
        end
      end
    end else begin
      good_cnt_r <= good_cnt_r;
      bad_cnt_r  <= bad_cnt_r;
    end
  end

  // RESOLVE lasts exactly one cycle and never overlaps a push because
  // in_ready is low there, so these decodes are single-cycle exclusive pulses.
  always_comb begin
    fifo_wr_ptr_upd = (state_r == RESOLVE) && good_r;
    fifo_flush      = (state_r == RESOLVE) && !good_r;
    pkt_dest        = pkt_dest_r;
    good_cnt        = good_cnt_r;
    bad_cnt         = bad_cnt_r;
  end

endmodule

// File: tb/tb_pkt_wr_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pkt_wr_ctrl
//
// Scoreboard bench for pkt_wr_ctrl. The driver builds whole packets, works out
// from the packet format which bytes must reach the fifo and whether the
// packet commits or flushes, and queues those expectations. A negedge monitor
// pops and compares whenever the DUT pushes a byte or pulses commit/flush.
// Counters are 2 bits wide here so saturation is reached quickly.
// -----------------------------------------------------------------------------
module tb_pkt_wr_ctrl;

  localparam int CW   = 2;
  localparam int MAXC = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    data_in = 8'd0;
  logic          data_valid = 1'b0;
  logic          in_ready;
  logic [7:0]    fifo_data;
  logic          fifo_push;
  logic          fifo_full = 1'b0;
  logic          fifo_wr_ptr_upd;
  logic          fifo_flush;
  logic [1:0]    pkt_dest;
  logic [CW-1:0] good_cnt;
  logic [CW-1:0] bad_cnt;

  pkt_wr_ctrl #(.CNT_WIDTH(CW)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .data_in         (data_in),
    .data_valid      (data_valid),
    .in_ready        (in_ready),
    .fifo_data       (fifo_data),
    .fifo_push       (fifo_push),
    .fifo_full       (fifo_full),
    .fifo_wr_ptr_upd (fifo_wr_ptr_upd),
    .fifo_flush      (fifo_flush),
    .pkt_dest        (pkt_dest),
    .good_cnt        (good_cnt),
    .bad_cnt         (bad_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic       good;
    logic [1:0] dest;
    int         gcnt;
    int         bcnt;
    int         cyc;
  } res_t;

  logic [7:0] push_q[$];
  res_t       res_q[$];
  logic [7:0] pkt_b[$];
  logic       pkt_f[$];

  int n_chk  = 0;
  int n_fail = 0;
  int mg = 0;
  int mb = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- monitor
  res_t pend;
  logic cnt_pend = 1'b0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (fifo_push) begin
        if (push_q.size() == 0) begin
          check("unexpected_push", 32'd1, 32'd0);
        end else begin
          check("push_data", fifo_data, push_q.pop_front());
        end
      end
      check("upd_flush_excl", fifo_wr_ptr_upd & fifo_flush, 32'd0);
      if (fifo_wr_ptr_upd || fifo_flush) begin
        check("pulse_with_push", fifo_push, 32'd0);
        check("in_ready_resolve", in_ready, 32'd0);
        if (res_q.size() == 0) begin
          check("unexpected_pulse", 32'd1, 32'd0);
        end else begin
          pend = res_q.pop_front();
          check("commit", fifo_wr_ptr_upd, pend.good);
          check("flush", fifo_flush, !pend.good);
          check("pkt_dest", pkt_dest, pend.dest);
          check("pulse_cycle", cyc, pend.cyc);
          cnt_pend = 1'b1;
        end
      end else begin
        check("in_ready_idle", in_ready, 32'd1);
        if (cnt_pend) begin
          check("good_cnt", good_cnt, pend.gcnt);
          check("bad_cnt", bad_cnt, pend.bcnt);
          cnt_pend = 1'b0;
        end
      end
    end
  end

  // ----------------------------------------------------------------- driver
  task automatic gap(input int k);
    repeat (k) begin
      @(posedge clk); #1;
      data_valid = 1'b0;
      fifo_full  = 1'b0;
      data_in    = 8'($urandom);
    end
  endtask

  // Present one byte; returns the cycle in which it gets accepted.
  task automatic send_byte(input logic [7:0] b, input logic full,
                           output int acc);
    int n;
    @(posedge clk); #1;
    data_in    = b;
    data_valid = 1'b1;
    fifo_full  = full;
    n = 0;
    while (in_ready !== 1'b1 && n < 8) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 8) check("in_ready_timeout", 32'd0, 32'd1);
    acc = cyc + 1;
  endtask

  // Send the packet in pkt_b/pkt_f; stop < 0 sends all of it, otherwise only
  // the first stop bytes (the packet is then abandoned, no result expected).
  task automatic run_pkt(input int maxgap, input int stop);
    int         len;
    int         nbytes;
    int         acc;
    logic [7:0] x;
    logic       spoiled;
    logic       good;
    res_t       r;
    len = int'(pkt_b[0][5:0]);
    x = 8'd0;
    spoiled = 1'b0;
    for (int i = 0; i <= len; i++) begin
      x = x ^ pkt_b[i];
      spoiled = spoiled | pkt_f[i];
    end
    good = (pkt_b[len+1] == x) && !spoiled;
    nbytes = (stop < 0) ? len + 2 : stop;
    if (nbytes == len + 2) begin
      if (good) mg = (mg == MAXC) ? MAXC : mg + 1;
      else      mb = (mb == MAXC) ? MAXC : mb + 1;
    end
    for (int i = 0; i < nbytes; i++) begin
      if (i > 0 && maxgap > 0 && $urandom_range(0, 2) == 0)
        gap($urandom_range(1, maxgap));
      send_byte(pkt_b[i], pkt_f[i], acc);
      if (i <= len && !pkt_f[i]) push_q.push_back(pkt_b[i]);
      if (i == len + 1) begin
        r.good = good;
        r.dest = pkt_b[0][7:6];
        r.gcnt = mg;
        r.bcnt = mb;
        r.cyc  = acc;
        res_q.push_back(r);
      end
    end
  endtask

  task automatic set_pkt5(input logic [7:0] crc, input int full_idx);
    pkt_b = '{8'h43, 8'h11, 8'h22, 8'h33, crc};
    pkt_f = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    if (full_idx >= 0) pkt_f[full_idx] = 1'b1;
  endtask

  task automatic build_rand_pkt();
    logic [7:0] h;
    logic [7:0] x;
    int         len;
    int         fidx;
    h = 8'($urandom);
    len = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 63)
                                      : $urandom_range(0, 6);
    h[5:0] = 6'(len);
    pkt_b.delete();
    pkt_f.delete();
    pkt_b.push_back(h);
    x = h;
    for (int i = 0; i < len; i++) begin
      pkt_b.push_back(8'($urandom));
      x = x ^ pkt_b[i+1];
    end
    if ($urandom_range(0, 4) == 0) x = x ^ 8'($urandom_range(1, 255));
    pkt_b.push_back(x);
    for (int i = 0; i < len + 2; i++) pkt_f.push_back(1'b0);
    if ($urandom_range(0, 6) == 0) begin
      fidx = $urandom_range(0, len + 1);
      pkt_f[fidx] = 1'b1;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, in_ready, 32'd1);
    check({tag, "_push"}, fifo_push, 32'd0);
    check({tag, "_upd"}, fifo_wr_ptr_upd, 32'd0);
    check({tag, "_flush"}, fifo_flush, 32'd0);
    check({tag, "_dest"}, pkt_dest, 32'd0);
    check({tag, "_good_cnt"}, good_cnt, 32'd0);
    check({tag, "_bad_cnt"}, bad_cnt, 32'd0);
  endtask

  // ------------------------------------------------------------------- main
  initial begin
    // reset held with a valid byte on the input: nothing may be pushed
    data_valid = 1'b1;
    data_in    = 8'h43;
    #12;
    check_reset_outputs("rst");
    @(posedge clk); #1;
    data_valid = 1'b0;
    rst_n = 1'b1;
    gap(2);

    // good packet, dest 1, back-to-back
    set_pkt5(8'h43, -1);
    run_pkt(0, -1);
    gap(3);
    // bad CRC
    set_pkt5(8'h44, -1);
    run_pkt(0, -1);
    gap(3);
    // zero-length packet, dest 2
    pkt_b = '{8'h80, 8'h80};
    pkt_f = '{1'b0, 1'b0};
    run_pkt(0, -1);
    gap(2);
    // fifo full on the 2nd payload byte of a correct packet
    set_pkt5(8'h43, 2);
    run_pkt(0, -1);
    gap(2);
    // stalls inside a packet, then the next packet immediately (saturates)
    set_pkt5(8'h43, -1);
    run_pkt(3, -1);
    pkt_b = '{8'h80, 8'h80};
    pkt_f = '{1'b0, 1'b0};
    run_pkt(0, -1);
    gap(4);

    // random traffic
    for (int p = 0; p < 120; p++) begin
      build_rand_pkt();
      run_pkt(($urandom_range(0, 1) == 0) ? 0 : 3, -1);
      if ($urandom_range(0, 3) == 0) gap($urandom_range(1, 3));
    end
    gap(3);

    // reset after header + 2 payload bytes
    set_pkt5(8'h43, -1);
    run_pkt(0, 3);
    @(posedge clk); #1;
    rst_n = 1'b0;
    data_valid = 1'b1;
    data_in = 8'hC5;
    mg = 0;
    mb = 0;
    #1;
    check_reset_outputs("midrst");
    repeat (2) begin
      @(posedge clk); #1;
      check_reset_outputs("midrst_hold");
    end
    data_valid = 1'b0;
    rst_n = 1'b1;
    gap(2);
    set_pkt5(8'h43, -1);
    run_pkt(0, -1);
    for (int p = 0; p < 20; p++) begin
      build_rand_pkt();
      run_pkt(2, -1);
    end
    gap(6);

    check("push_q_drained", push_q.size(), 32'd0);
    check("res_q_drained", res_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
